ir_recv: RTL and testbench
==========================

# ir_recv

NEC infrared receiver. It takes the demodulated output of an IR receiver module (TSOP-style, 38 kHz carrier already stripped) and measures mark and space widths against the NEC timing windows. It decodes the 32-bit frame (address, inverted address, command, inverted command, LSB first) and presents the validated address and command with a one-cycle strobe. It sits beside `ir_send` in the IR subsystem and is the receiving end of the same protocol.

## Interface
- `AGC_CYCLES`, 900_000: nominal leader mark (9 ms at 100 MHz)
- `SPACE_CYCLES`, 450_000: nominal leader space (4.5 ms)
- `REPEAT_SPACE_CYCLES`, 225_000: nominal repeat-code space (2.25 ms)
- `MARK_CYCLES`, 56_000: nominal bit/stop mark (560 us)
- `ZERO_SPACE_CYCLES`, 56_500: nominal '0' space (565 us)
- `ONE_SPACE_CYCLES`, 169_000: nominal '1' space (1.69 ms)
- `TOL_PCT`, 25: symmetric acceptance tolerance, percent of nominal
- `ACTIVE_LOW`, 1: 1 = `ir_rx` low means carrier present
- `clk`  input  1  system clock, 100 MHz
- `rst_n`  input  1  reset, asynchronous, active-low
- `ir_rx`  input  1  raw demodulated IR line, asynchronous to `clk`
- `addr`  output  8  last valid address
- `cmd`  output  8  last valid command
- `valid`  output  1  one-cycle pulse: new `addr`/`cmd`
- `err`  output  1  one-cycle pulse: frame aborted
- `repeat`  output  1  one-cycle pulse: repeat code (macro only; tied 0 otherwise)
- `busy`  output  1  high whenever state != S_IDLE

## Operation
- Input path:
  - 2-FF synchronizer, then `mark` = synced `ir_rx` XOR `ACTIVE_LOW` inverted (1 = carrier present).
  - `mark_d` is `mark` delayed one cycle.
  - mark_rise = mark & ~mark_d; mark_fall = ~mark & mark_d.
  - Sync FFs and `mark_d` reset to the no-carrier level.
- Timer `tim`, 21 bits:
  - Counts cycles since the last `mark` edge and saturates at all-ones.
  - Reloads to 1 on any edge.
  - Window checks on an edge use the pre-reload value.
- Windows, inclusive: MIN = N − N·TOL_PCT/100, MAX = N + N·TOL_PCT/100, integer arithmetic.
- States:
  - S_IDLE: `tim` ignored; mark_rise → S_AGC. A line stuck in mark never retriggers, because only an edge starts a frame.
  - S_AGC: on mark_fall, AGC window → S_LSPACE.
  - S_LSPACE:
    - on mark_rise, SPACE window → S_MARK, `bit_cnt` ← 0;
    - REPEAT_SPACE window (macro only) → S_RMARK.
  - S_MARK: on mark_fall, MARK window → S_BSPACE.
  - S_BSPACE:
    - on mark_rise, ZERO window shifts in 0 and ONE window shifts in 1;
    - shift is `data` ← {bit, data[31:1]};
    - `bit_cnt`==31 → S_STOP, else `bit_cnt`+1 → S_MARK.
  - S_STOP: on mark_fall, MARK window:
    - data[15:8]==~data[7:0] and data[31:24]==~data[23:16] → `addr`←data[7:0], `cmd`←data[23:16], `valid` pulse;
    - otherwise `err` pulse;
    - either way → S_IDLE.
  - S_RMARK: on mark_fall, MARK window → `repeat` pulse, S_IDLE.
- Any edge outside its window in any non-idle state → `err` pulse, S_IDLE.
- Timeout: in any non-idle state, `tim` > current state's window MAX with no edge → `err` pulse, S_IDLE. The S_BSPACE bound is the ONE MAX.
- `addr`/`cmd` change only on `valid`; errors and repeats never modify them.
- `valid`, `err` and `repeat` are mutually exclusive.

## Timing
- Reset values: `addr`=0, `cmd`=0, `valid`=0, `err`=0, `repeat`=0, `busy`=0; state S_IDLE, `tim`=0, `bit_cnt`=0, `data`=0.
- Latency: `valid`/`err`/`repeat` assert on the 3rd rising `clk` after the first edge that samples the final `ir_rx` transition, for exactly one cycle. `addr`/`cmd` update on the same edge as `valid`.
- Timeout `err` asserts one cycle after `tim` first exceeds MAX.
- `rst_n` low mid-frame aborts immediately with no `err` pulse, and the partial frame is discarded.
- After any return to S_IDLE, a frame can start on the next mark_rise. No dead time.

## Configuration
- `IR_RECV_REPEAT_EN` defined:
  - S_RMARK is built;
  - a leader space in the REPEAT window leads to S_RMARK and a `repeat` pulse;
  - `addr`/`cmd` are unchanged.
- Not defined:
  - S_RMARK is removed and `repeat` is tied 0;
  - a repeat-window leader space is an out-of-window edge → `err`.

## Test plan
- Ideal NEC frame, addr 0x5A, cmd 0x3C (data 0xC33CA55A LSB first) → `valid` pulse, `addr`=0x5A, `cmd`=0x3C, `err`=0.
- All pulse widths +20 % and then −20 % → `valid` each time. At ±30 % → `err`, with `addr`/`cmd` retaining their prior values.
- Frame with inverted address 0xA4 (should be 0xA5) → `err` pulse after the stop mark; `addr`/`cmd` unchanged.
- Repeat code (9 ms mark, 2.25 ms space, 560 us mark):
  - with macro → `repeat` pulse, no `valid`;
  - without macro → `err` pulse.
- Line held idle after bit 10 → `err` exactly one cycle after `tim` reaches 211_251; `busy` falls the same cycle. A 100 us mark afterwards → `err` on its fall.
- `rst_n` pulsed low after bit 20, then a full frame with addr 0x01, cmd 0x80 → no pulses during reset, then `valid` with `addr`=0x01, `cmd`=0x80.

Source files
------------

// File: rtl/ir_recv_if.sv
// ir_recv result bundle: decoded address/command plus status strobes.
// repeat_code carries the repeat pulse (repeat is a reserved word).
interface ir_recv_if;
    logic [7:0] addr;
    logic [7:0] cmd;
    logic       valid;
    logic       err;
    logic       repeat_code;
    logic       busy;

    modport master (
        output addr, cmd, valid, err, repeat_code, busy
    );
    modport slave (
        input addr, cmd, valid, err, repeat_code, busy
    );
endinterface

// File: rtl/ir_recv.sv
// NEC infrared receiver: measures mark/space widths, decodes a 32-bit frame.
// Define IR_RECV_REPEAT_EN to accept NEC repeat codes.
module ir_recv #(
    parameter int AGC_CYCLES          = 900_000,
    parameter int SPACE_CYCLES        = 450_000,
    parameter int REPEAT_SPACE_CYCLES = 225_000,
    parameter int MARK_CYCLES         = 56_000,
    parameter int ZERO_SPACE_CYCLES   = 56_500,
    parameter int ONE_SPACE_CYCLES    = 169_000,
    parameter int TOL_PCT             = 25,
    parameter bit ACTIVE_LOW          = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      ir_rx,
    ir_recv_if.master bus
);
    localparam logic [20:0] AGC_LO = 21'(AGC_CYCLES - AGC_CYCLES * TOL_PCT / 100);
    localparam logic [20:0] AGC_HI = 21'(AGC_CYCLES + AGC_CYCLES * TOL_PCT / 100);
    localparam logic [20:0] SPC_LO = 21'(SPACE_CYCLES - SPACE_CYCLES * TOL_PCT / 100);
    localparam logic [20:0] SPC_HI = 21'(SPACE_CYCLES + SPACE_CYCLES * TOL_PCT / 100);
    localparam logic [20:0] REP_HI =
        21'(REPEAT_SPACE_CYCLES + REPEAT_SPACE_CYCLES * TOL_PCT / 100);
    localparam logic [20:0] MRK_LO = 21'(MARK_CYCLES - MARK_CYCLES * TOL_PCT / 100);
    localparam logic [20:0] MRK_HI = 21'(MARK_CYCLES + MARK_CYCLES * TOL_PCT / 100);
    localparam logic [20:0] ZER_LO =
        21'(ZERO_SPACE_CYCLES - ZERO_SPACE_CYCLES * TOL_PCT / 100);
    localparam logic [20:0] ZER_HI =
        21'(ZERO_SPACE_CYCLES + ZERO_SPACE_CYCLES * TOL_PCT / 100);
    localparam logic [20:0] ONE_LO =
        21'(ONE_SPACE_CYCLES - ONE_SPACE_CYCLES * TOL_PCT / 100);
    localparam logic [20:0] ONE_HI =
        21'(ONE_SPACE_CYCLES + ONE_SPACE_CYCLES * TOL_PCT / 100);
    localparam logic [20:0] LSP_HI = (SPC_HI > REP_HI) ? SPC_HI : REP_HI;
`ifdef IR_RECV_REPEAT_EN
    localparam logic [20:0] REP_LO =
        21'(REPEAT_SPACE_CYCLES - REPEAT_SPACE_CYCLES * TOL_PCT / 100);

    typedef enum logic [2:0] {
        S_IDLE, S_AGC, S_LSPACE, S_MARK, S_BSPACE, S_STOP, S_RMARK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_AGC, S_LSPACE, S_MARK, S_BSPACE, S_STOP
    } state_t;
`endif

    function automatic logic in_win(
        input logic [20:0] t,
        input logic [20:0] lo,
        input logic [20:0] hi
    );
        return (t >= lo) && (t <= hi);
    endfunction

    state_t      state, state_n;
    logic        sync1, sync2, mark, mark_d, rise, fall;
    logic [20:0] tim, tmax;
    logic [4:0]  bit_cnt, bit_cnt_n;
    logic [31:0] data, data_n;
    logic [7:0]  addr_q, addr_n, cmd_q, cmd_n;
    logic        valid_q, valid_n, err_q, err_n;

    assign mark = sync2 ^ ACTIVE_LOW;
    assign rise = mark & ~mark_d;
    assign fall = ~mark & mark_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= ACTIVE_LOW;
            sync2   <= ACTIVE_LOW;
            mark_d  <= 1'b0;
            tim     <= '0;
            state   <= S_IDLE;
            bit_cnt <= '0;
            data    <= '0;
            addr_q  <= '0;
            cmd_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1   <= ir_rx;
            sync2   <= sync1;
            mark_d  <= mark;
            if (rise || fall)
                tim <= 21'd1;
            else if (tim != '1)
                tim <= tim + 21'd1;
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            data    <= data_n;
            addr_q  <= addr_n;
            cmd_q   <= cmd_n;
            valid_q <= valid_n;
            err_q   <= err_n;
        end
    end

`ifdef IR_RECV_REPEAT_EN
    logic rep_q, rep_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep_q <= 1'b0;
        else        rep_q <= rep_n;
    end

    assign bus.repeat_code = rep_q;
`else
    assign bus.repeat_code = 1'b0;
`endif

    always_comb begin
        unique case (state)
            S_AGC:           tmax = AGC_HI;
            S_LSPACE:        tmax = LSP_HI;
            S_MARK, S_STOP:  tmax = MRK_HI;
            S_BSPACE:        tmax = ONE_HI;
`ifdef IR_RECV_REPEAT_EN
            S_RMARK:         tmax = MRK_HI;
`endif
            default:         tmax = '1;
        endcase
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        data_n    = data;
        addr_n    = addr_q;
        cmd_n     = cmd_q;
        valid_n   = 1'b0;
        err_n     = 1'b0;
`ifdef IR_RECV_REPEAT_EN
        rep_n     = 1'b0;
`endif
        if (state != S_IDLE && !rise && !fall && tim > tmax) begin
            err_n   = 1'b1;
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: if (rise) state_n = S_AGC;
                S_AGC: if (fall) begin
                    if (in_win(tim, AGC_LO, AGC_HI)) state_n = S_LSPACE;
                    else begin err_n = 1'b1; state_n = S_IDLE; end
                end
                S_LSPACE: if (rise) begin
                    if (in_win(tim, SPC_LO, SPC_HI)) begin
                        state_n   = S_MARK;
                        bit_cnt_n = '0;
                    end
`ifdef IR_RECV_REPEAT_EN
                    else if (in_win(tim, REP_LO, REP_HI)) state_n = S_RMARK;
`endif
                    else begin err_n = 1'b1; state_n = S_IDLE; end
                end
                S_MARK: if (fall) begin
                    if (in_win(tim, MRK_LO, MRK_HI)) state_n = S_BSPACE;
                    else begin err_n = 1'b1; state_n = S_IDLE; end
                end
                S_BSPACE: if (rise) begin
                    if (in_win(tim, ONE_LO, ONE_HI) ||
                        in_win(tim, ZER_LO, ZER_HI)) begin
                        data_n = {in_win(tim, ONE_LO, ONE_HI), data[31:1]};
                        if (bit_cnt == 5'd31) state_n = S_STOP;
                        else begin
                            bit_cnt_n = bit_cnt + 5'd1;
                            state_n   = S_MARK;
                        end
                    end else begin err_n = 1'b1; state_n = S_IDLE; end
                end
                S_STOP: if (fall) begin
                    state_n = S_IDLE;
                    // both bytes must match their inverted copies
                    if (in_win(tim, MRK_LO, MRK_HI) &&
                        data[15:8] == ~data[7:0] &&
                        data[31:24] == ~data[23:16]) begin
                        addr_n  = data[7:0];
                        cmd_n   = data[23:16];
                        valid_n = 1'b1;
                    end else err_n = 1'b1;
                end
`ifdef IR_RECV_REPEAT_EN
                S_RMARK: if (fall) begin
                    state_n = S_IDLE;
                    if (in_win(tim, MRK_LO, MRK_HI)) rep_n = 1'b1;
                    else err_n = 1'b1;
                end
`endif
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign bus.addr  = addr_q;
    assign bus.cmd   = cmd_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
    assign bus.busy  = (state != S_IDLE);
endmodule

// File: tb/tb_ir_recv.sv
// Directed bench for ir_recv using scaled-down NEC timings.
// Scaled nominals: AGC 200, space 100, repeat 50, mark 20, zero 20, one 60.
module tb_ir_recv;
    localparam int AGC = 200;
    localparam int SP  = 100;
    localparam int RSP = 50;
    localparam int MK  = 20;
    localparam int ZS  = 20;
    localparam int OS  = 60;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ir_rx = 1'b1;

    ir_recv_if bus();

    ir_recv #(
        .AGC_CYCLES(AGC),
        .SPACE_CYCLES(SP),
        .REPEAT_SPACE_CYCLES(RSP),
        .MARK_CYCLES(MK),
        .ZERO_SPACE_CYCLES(ZS),
        .ONE_SPACE_CYCLES(OS),
        .TOL_PCT(25),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ir_rx(ir_rx),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int nv = 0;
    int ne = 0;
    int nr = 0;

    always @(posedge clk) begin
        #2;
        if (bus.valid === 1'b1) nv++;
        if (bus.err === 1'b1) ne++;
        if (bus.repeat_code === 1'b1) nr++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        ir_rx = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_body(input logic [31:0] d, input int pct,
                              input int nbits);
        hold(1'b0, AGC * pct / 100);
        hold(1'b1, SP * pct / 100);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b0, MK * pct / 100);
            hold(1'b1, (d[i] ? OS : ZS) * pct / 100);
        end
    endtask

    task automatic finish_watch(output int first);
        ir_rx = 1'b1;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (first == 0 &&
                (bus.valid | bus.err | bus.repeat_code) === 1'b1)
                first = i;
        end
    endtask

    task automatic send_frame(input logic [31:0] d, input int pct,
                              output int first);
        frame_body(d, pct, 32);
        hold(1'b0, MK * pct / 100);
        finish_watch(first);
    endtask

    int first, v0, e0, r0;
    logic b78, e78, b79;

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_addr", 32'(bus.addr), 32'h0);
        chk("rst_cmd", 32'(bus.cmd), 32'h0);
        chk("rst_flags", 32'({bus.valid, bus.err, bus.repeat_code, bus.busy}), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'h0);

        v0 = nv; e0 = ne;
        send_frame(32'hC33CA55A, 100, first);
        chk("ideal_lat", 32'(first), 32'd3);
        chk("ideal_valid", 32'(nv - v0), 32'd1);
        chk("ideal_err", 32'(ne - e0), 32'd0);
        chk("ideal_addr", 32'(bus.addr), 32'h5A);
        chk("ideal_cmd", 32'(bus.cmd), 32'h3C);

        v0 = nv; e0 = ne;
        send_frame(32'hCB34ED12, 120, first);
        chk("p20_valid", 32'(nv - v0), 32'd1);
        chk("p20_err", 32'(ne - e0), 32'd0);
        chk("p20_addr", 32'(bus.addr), 32'h12);
        chk("p20_cmd", 32'(bus.cmd), 32'h34);

        v0 = nv; e0 = ne;
        send_frame(32'hC33CA55A, 80, first);
        chk("m20_lat", 32'(first), 32'd3);
        chk("m20_valid", 32'(nv - v0), 32'd1);
        chk("m20_addr", 32'(bus.addr), 32'h5A);
        chk("m20_cmd", 32'(bus.cmd), 32'h3C);

        v0 = nv; e0 = ne;
        send_frame(32'hCB34ED12, 130, first);
        chk("p30_valid", 32'(nv - v0), 32'd0);
        chk("p30_err", 32'(ne - e0), 32'd34);
        chk("p30_addr", 32'(bus.addr), 32'h5A);
        chk("p30_cmd", 32'(bus.cmd), 32'h3C);

        v0 = nv; e0 = ne;
        send_frame(32'hCB34ED12, 70, first);
        chk("m30_valid", 32'(nv - v0), 32'd0);
        chk("m30_err", 32'(ne - e0), 32'd34);
        chk("m30_addr", 32'(bus.addr), 32'h5A);

        v0 = nv; e0 = ne;
        send_frame(32'hC33CA45A, 100, first);
        chk("inv_lat", 32'(first), 32'd3);
        chk("inv_err", 32'(ne - e0), 32'd1);
        chk("inv_valid", 32'(nv - v0), 32'd0);
        chk("inv_addr", 32'(bus.addr), 32'h5A);
        chk("inv_cmd", 32'(bus.cmd), 32'h3C);

        v0 = nv; e0 = ne; r0 = nr;
        hold(1'b0, AGC);
        hold(1'b1, RSP);
        hold(1'b0, MK);
        finish_watch(first);
        chk("rep_valid", 32'(nv - v0), 32'd0);
`ifdef IR_RECV_REPEAT_EN
        chk("rep_lat", 32'(first), 32'd3);
        chk("rep_pulse", 32'(nr - r0), 32'd1);
        chk("rep_err", 32'(ne - e0), 32'd0);
`else
        chk("rep_pulse", 32'(nr - r0), 32'd0);
        chk("rep_err", 32'(ne - e0), 32'd1);
`endif
        chk("rep_addr", 32'(bus.addr), 32'h5A);

        // stall in the bit-10 space; tim hits ONE max + 1 = 76 after edge 78
        e0 = ne;
        frame_body(32'hC33CA55A, 100, 10);
        hold(1'b0, MK);
        ir_rx = 1'b1;
        first = 0;
        b78 = 1'b0; e78 = 1'b1; b79 = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 78) begin b78 = bus.busy; e78 = bus.err; end
            if (i == 79) b79 = bus.busy;
            if (first == 0 && bus.err === 1'b1) first = i;
        end
        chk("to_cycle", 32'(first), 32'd79);
        chk("to_busy_before", 32'(b78), 32'd1);
        chk("to_err_before", 32'(e78), 32'd0);
        chk("to_busy_after", 32'(b79), 32'd0);
        chk("to_err_count", 32'(ne - e0), 32'd1);

        e0 = ne;
        hold(1'b0, 4);
        finish_watch(first);
        chk("short_lat", 32'(first), 32'd3);
        chk("short_err", 32'(ne - e0), 32'd1);

        v0 = nv; e0 = ne; r0 = nr;
        frame_body(32'hC33CA55A, 100, 20);
        rst_n = 1'b0;
        hold(1'b1, 5);
        chk("rstmid_pulses", 32'((nv - v0) + (ne - e0) + (nr - r0)), 32'd0);
        chk("rstmid_busy", 32'(bus.busy), 32'd0);
        chk("rstmid_addr", 32'(bus.addr), 32'h0);
        rst_n = 1'b1;
        hold(1'b1, 5);
        chk("post_rst_pulses", 32'((nv - v0) + (ne - e0) + (nr - r0)), 32'd0);

        v0 = nv; e0 = ne;
        send_frame(32'h7F80FE01, 100, first);
        chk("after_rst_lat", 32'(first), 32'd3);
        chk("after_rst_valid", 32'(nv - v0), 32'd1);
        chk("after_rst_err", 32'(ne - e0), 32'd0);
        chk("after_rst_addr", 32'(bus.addr), 32'h01);
        chk("after_rst_cmd", 32'(bus.cmd), 32'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
